// File: rtl/button_conditioner_pkg.sv
// Shared board constants for the button front end.
//   CLK_HZ, DEBOUNCE_MS, LONG_PRESS_MS : board timing
//   ms_to_cycles()                     : converts milliseconds to CLK cycles
//   btn_state_t, ST_RELEASED/PRESSED   : debounced level encoding (active-high)
package button_conditioner_pkg;

  localparam int CLK_HZ        = 25_000_000;
  localparam int DEBOUNCE_MS   = 10;
  localparam int LONG_PRESS_MS = 1000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEF = ms_to_cycles(DEBOUNCE_MS);
  localparam int LONG_CYCLES_DEF     = ms_to_cycles(LONG_PRESS_MS);

  typedef logic [0:0] btn_state_t;
  localparam btn_state_t ST_RELEASED = 1'b0;
  localparam btn_state_t ST_PRESSED  = 1'b1;

endpackage

// File: rtl/button_conditioner_btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter debouncer, registered
// press/release pulses and a saturating long-press detector.
//   CLK, rst_n  : clock, asynchronous active-low reset
//   raw_i       : polarity-corrected raw pin (1 = pressed), asynchronous
//   level_o     : debounced level
//   press_o     : 1-cycle pulse on debounced 0->1
//   release_o   : 1-cycle pulse on debounced 1->0
//   long_o      : 1-cycle pulse once the level has been held LONG_CYCLES
module button_conditioner_btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_FIRE = HW'(LONG_CYCLES - 1);

  logic            sync1_q, sync2_q;
  btn_state_t      state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;

  // Debounce: any sample equal to the stable level restarts the count, so
  // only DEBOUNCE_CYCLES consecutive differing samples flip the level.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (btn_state_t'(sync2_q) != state_q) begin
      if (dcnt_q == DCNT_LAST) begin
        state_d   = btn_state_t'(sync2_q);
        press_d   = (btn_state_t'(sync2_q) == ST_PRESSED);
        release_d = (btn_state_t'(sync2_q) == ST_RELEASED);
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Hold counter runs on the registered level, so it starts counting the
  // cycle after the press pulse and saturates to give a single long pulse.
  always_comb begin
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    if (state_q == ST_RELEASED) begin
      hcnt_d = '0;
    end else if (hcnt_q != HCNT_SAT) begin
      hcnt_d = hcnt_q + HW'(1);
      long_d = (hcnt_q == HCNT_FIRE);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_RELEASED;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = state_q[0];
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board push-buttons for the 4-bit CPU core.
//   CLK, rst_n   : clock, asynchronous active-low reset
//   btn_raw      : raw bouncing pins (polarity set by ACTIVE_LOW)
//   btn_level    : debounced levels, 1 = pressed
//   btn_press    : 1-cycle pulses on debounced press
//   btn_release  : 1-cycle pulses on debounced release
//   btn_long     : 1-cycle pulses after LONG_CYCLES of holding
// Every output is registered; there is no combinational path from btn_raw.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam logic POL_INV = (ACTIVE_LOW != 0);

  // Invert ahead of the synchroniser so all internal logic is active-high.
  logic [NUM_BTN-1:0] raw_pol;
  assign raw_pol = btn_raw ^ {NUM_BTN{POL_INV}};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_conditioner_btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .raw_i    (raw_pol[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g]),
      .long_o   (btn_long[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int NB = 4;
  localparam int DC = 4;
  localparam int LC = 10;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw, raw_al;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
  logic [NB-1:0] lvl_al, prs_al, rel_al, lng_al;

  always #5 CLK = ~CLK;

  button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(0)) dut (
    .CLK(CLK), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long));

  button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1)) dut_al (
    .CLK(CLK), .rst_n(rst_n), .btn_raw(raw_al),
    .btn_level(lvl_al), .btn_press(prs_al), .btn_release(rel_al), .btn_long(lng_al));

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } obs_t;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_lvl;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  obs_t sb[$];

  // Reference model state
  logic [3:0] m_s1, m_s2, m_L;
  int         m_d[4];
  int         m_h[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    return {btn_level, btn_press, btn_release, btn_long};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_L = '0;
    for (int c = 0; c < NB; c++) begin
      m_d[c] = 0;
      m_h[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] r, output obs_t e);
    obs_t o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      logic held;
      held = m_L[c];
      if (m_s2[c] == m_L[c]) m_d[c] = 0;
      else if (m_d[c] == DC - 1) begin
        m_L[c] = m_s2[c];
        m_d[c] = 0;
        if (m_s2[c]) o.prs[c] = 1'b1;
        else         o.rel[c] = 1'b1;
      end else m_d[c]++;
      if (!held) m_h[c] = 0;
      else if (m_h[c] < LC) begin
        m_h[c]++;
        if (m_h[c] == LC) o.lng[c] = 1'b1;
      end
    end
    m_s2 = m_s1;
    m_s1 = r;
    o.lvl = m_L;
    e = o;
  endtask

  // One clock: drive at negedge, push expectation, compare after the edge.
  task automatic step(input logic [3:0] r, output obs_t act);
    obs_t e;
    @(negedge CLK);
    btn_raw = r;
    if (rst_n) model_edge(r, e);
    else       e = '0;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    act = dut_obs();
    chk("scoreboard", act, sb.pop_front());
  endtask

  initial begin
    obs_t       o;
    int         n1, n2;
    logic [15:0] acc;
    vec_t       tbl[10];
    logic [3:0] bseq[5];

    tbl[0] = '{4'h0, 10, 4'h0};
    tbl[1] = '{4'h2,  8, 4'h2};
    tbl[2] = '{4'h0,  8, 4'h0};
    tbl[3] = '{4'h6,  3, 4'h0};
    tbl[4] = '{4'h0,  8, 4'h0};
    tbl[5] = '{4'hC,  8, 4'hC};
    tbl[6] = '{4'h4,  8, 4'h4};
    tbl[7] = '{4'h0,  8, 4'h0};
    tbl[8] = '{4'hF,  8, 4'hF};
    tbl[9] = '{4'h0,  8, 4'h0};
    bseq[0] = 4'h2; bseq[1] = 4'h0; bseq[2] = 4'h2; bseq[3] = 4'h2; bseq[4] = 4'h0;

    // Reset held with all buttons pressed
    rst_n = 1'b0; btn_raw = 4'hF; raw_al = 4'hF;
    model_reset();
    repeat (3) step(4'hF, o);
    chk("rst_outputs", 16'(o), 16'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(4'hF, o);
      if (e < 6)       chk("t1_quiet", 16'(o), 16'h0);
      else if (e == 6) chk("t1_press", 16'(o), 16'hFF00);
      else             chk("t1_after", 16'(o), 16'hF000);
    end
    repeat (10) step(4'h0, o);
    chk("t1_released", 16'(o.lvl), 16'h0);
    chk("al_idle", 16'(lvl_al), 16'h0);

    // Table of level segments
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].hold; k++) step(tbl[i].raw, o);
      chk($sformatf("tbl%0d_level", i), 16'(o.lvl), 16'(tbl[i].exp_lvl));
    end

    // Clean press on bit0 held 30 cycles, then release
    n1 = 0;
    for (int e = 1; e <= 30; e++) begin
      step(4'h1, o);
      if (e == 6)  chk("t2_press", 16'({o.lvl, o.prs}), 16'h11);
      if (e == 16) chk("t2_long", 16'(o.lng), 16'h1);
      n1 += int'(o.lng[0]);
    end
    chk("t2_long_once", 16'(n1), 16'd1);
    for (int e = 1; e <= 8; e++) begin
      step(4'h0, o);
      if (e == 6) chk("t2_release", 16'({o.lvl, o.rel}), 16'h01);
    end

    // Bounce on bit1 then steady press
    n1 = 0; n2 = 0;
    for (int i = 0; i < 5; i++) begin
      step(bseq[i], o);
      n1 += int'(o.prs[1]); n2 += int'(o.rel[1]);
    end
    for (int e = 1; e <= 10; e++) begin
      step(4'h2, o);
      if (e == 6) chk("t3_press", 16'(o.prs), 16'h2);
      n1 += int'(o.prs[1]); n2 += int'(o.rel[1]);
    end
    chk("t3_single", 16'(n1), 16'd1);
    chk("t3_norel", 16'(n2), 16'd0);
    repeat (8) step(4'h0, o);

    // Short glitch on bit2
    acc = '0;
    repeat (3) begin step(4'h4, o); acc |= 16'(o); end
    repeat (8) begin step(4'h0, o); acc |= 16'(o); end
    chk("t4_quiet", acc, 16'h0);

    // Simultaneous press on bits 0 and 3
    for (int e = 1; e <= 8; e++) begin
      step(4'h9, o);
      if (e == 6) chk("t5_press", 16'({o.lvl, o.prs}), 16'h99);
    end
    repeat (8) step(4'h0, o);

    // Reset mid-hold, button kept pressed through reset release
    for (int e = 1; e <= 11; e++) begin
      step(4'h1, o);
      if (e == 6) chk("t6_press", 16'(o.prs), 16'h1);
    end
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_now", 16'(dut_obs()), 16'h0);
    model_reset();
    acc = '0;
    repeat (3) begin step(4'h1, o); acc |= 16'(o.lng); end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(4'h1, o);
      if (e < 6) acc |= 16'(o);
      if (e == 6) chk("t6_fresh_press", 16'(o.prs), 16'h1);
    end
    chk("t6_nolong", acc, 16'h0);
    repeat (8) step(4'h0, o);

    // Active-low instance
    raw_al = 4'b1110;
    for (int e = 1; e <= 7; e++) begin
      step(4'h0, o);
      if (e == 6) chk("al_press", 16'(prs_al), 16'h1);
    end
    chk("al_level", 16'(lvl_al), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
